// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU-side request/response signals and the byte-wide main memory port.
// The arbiter uses the master view; the CPU and memory environment use the slave view.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32
);
  logic                  inst_req;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic [LEN-1:0]        inst_data;
  logic                  inst_done;

  logic [1:0]            data_vis_signal;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [1:0]            data_size;
  logic [LEN-1:0]        data_wdata;
  logic [LEN-1:0]        data_rdata;
  logic                  data_done;

  logic [ADDR_WIDTH-1:0] mem_vis_addr;
  logic [1:0]            mem_vis_signal;
  logic [7:0]            mem_writen_data;
  logic [7:0]            mem_data;

  logic                  busy;

  modport master (
    input  inst_req, inst_addr, data_vis_signal, data_addr, data_size, data_wdata, mem_data,
    output inst_data, inst_done, data_rdata, data_done,
           mem_vis_addr, mem_vis_signal, mem_writen_data, busy
  );

  modport slave (
    output inst_req, inst_addr, data_vis_signal, data_addr, data_size, data_wdata, mem_data,
    input  inst_data, inst_done, data_rdata, data_done,
           mem_vis_addr, mem_vis_signal, mem_writen_data, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Grants the byte-wide memory port to instruction fetch or data access (data first),
// serialising 1/2/4-byte little-endian transfers into consecutive byte cycles.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state, state_next;
  logic                  owner_data;
  logic                  is_write;
  logic [ADDR_WIDTH-1:0] base;
  logic [2:0]            n_bytes;
  logic [2:0]            k;
  logic [LEN-1:0]        wdata_q;
  logic [LEN-1:0]        asm_q, asm_next;
  logic [LEN-1:0]        inst_data_q, data_rdata_q;
  logic                  grant_data, grant_inst;
  logic                  capture;
  logic [1:0]            lane;
  logic [2:0]            data_n;

  always_comb begin
    grant_data = (bus.data_vis_signal == 2'b01) || (bus.data_vis_signal == 2'b10);
    grant_inst = !grant_data && bus.inst_req;
    case (bus.data_size)
      2'b00:   data_n = 3'd1;
      2'b01:   data_n = 3'd2;
      default: data_n = 3'd4;
    endcase
  end

  // A read byte arrives one cycle after its command, so it lands in lane k-1.
  always_comb begin
    capture  = !is_write && (((state == ISSUE) && (k != 3'd0)) || (state == DRAIN));
    lane     = k[1:0] - 2'd1;
    asm_next = asm_q;
    if (capture) asm_next[{lane, 3'b000} +: 8] = bus.mem_data;
  end

  always_comb begin
    state_next          = state;
    bus.mem_vis_addr    = '0;
    bus.mem_vis_signal  = 2'b00;
    bus.mem_writen_data = 8'h00;
    case (state)
      IDLE: if (grant_data || grant_inst) state_next = ISSUE;
      ISSUE: begin
        bus.mem_vis_addr   = base + ADDR_WIDTH'(k);
        bus.mem_vis_signal = is_write ? 2'b10 : 2'b01;
        if (is_write) bus.mem_writen_data = wdata_q[{k[1:0], 3'b000} +: 8];
        if (k == n_bytes - 3'd1) state_next = is_write ? DONE : DRAIN;
      end
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.inst_done  = (state == DONE) && !owner_data;
    bus.data_done  = (state == DONE) && owner_data;
    bus.busy       = (state != IDLE);
    bus.inst_data  = inst_data_q;
    bus.data_rdata = data_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner_data   <= 1'b0;
      is_write     <= 1'b0;
      base         <= '0;
      n_bytes      <= 3'd0;
      k            <= 3'd0;
      wdata_q      <= '0;
      asm_q        <= '0;
      inst_data_q  <= '0;
      data_rdata_q <= '0;
    end else begin
      state <= state_next;
      asm_q <= asm_next;
      case (state)
        IDLE: if (grant_data || grant_inst) begin
          owner_data <= grant_data;
          base       <= grant_data ? bus.data_addr : bus.inst_addr;
          n_bytes    <= grant_data ? data_n : 3'd4;
          is_write   <= grant_data && (bus.data_vis_signal == 2'b10);
          wdata_q    <= grant_data ? bus.data_wdata : '0;
          k          <= 3'd0;
          asm_q      <= '0;
        end
        ISSUE: k <= k + 3'd1;
        // The final byte is merged on the way out of DRAIN so DONE sees the full word.
        DRAIN: begin
          if (owner_data) data_rdata_q <= asm_next;
          else            inst_data_q  <= asm_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-wide memory model answering one cycle after each read.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_arbiter_if #(.ADDR_WIDTH(17), .LEN(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(17), .LEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem [0:(1<<17)-1];
  logic [7:0]  rd_byte;
  logic        poke_en;
  logic [16:0] poke_addr;
  logic [7:0]  poke_val;

  // Memory model: writes land at the command edge, read data appears the following cycle.
  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_val;
    else if (bus.mem_vis_signal == 2'b10) mem[bus.mem_vis_addr] <= bus.mem_writen_data;
    if (bus.mem_vis_signal == 2'b01) rd_byte <= mem[bus.mem_vis_addr];
  end
  assign bus.mem_data = rd_byte;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic poke(input logic [16:0] a, input logic [7:0] v);
    poke_addr = a;
    poke_val  = v;
    poke_en   = 1'b1;
    tick();
    poke_en   = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [1:0] sig, input logic [16:0] addr,
                                input logic [1:0] size, input logic [31:0] wdata);
    bus.data_vis_signal = sig;
    bus.data_addr       = addr;
    bus.data_size       = size;
    bus.data_wdata      = wdata;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [31:0] word;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    poke_en = 1'b0;
    poke_addr = '0;
    poke_val = '0;
    bus.inst_req  = 1'b0;
    bus.inst_addr = '0;
    apply_stimulus(2'b00, 17'h0, 2'b00, 32'h0);
    repeat (2) tick();

    check_output("rst_sig",   32'(bus.mem_vis_signal), 32'h0);
    check_output("rst_addr",  32'(bus.mem_vis_addr), 32'h0);
    check_output("rst_wdat",  32'(bus.mem_writen_data), 32'h0);
    check_output("rst_idata", bus.inst_data, 32'h0);
    check_output("rst_rdata", bus.data_rdata, 32'h0);
    check_output("rst_idone", 32'(bus.inst_done), 32'h0);
    check_output("rst_ddone", 32'(bus.data_done), 32'h0);
    check_output("rst_busy",  32'(bus.busy), 32'h0);

    poke(17'h00010, 8'h13); poke(17'h00011, 8'h05);
    poke(17'h00012, 8'h00); poke(17'h00013, 8'h00);
    poke(17'h00101, 8'h77);
    poke(17'h00020, 8'h11); poke(17'h00021, 8'h22);
    poke(17'h00022, 8'h33); poke(17'h00023, 8'h44);
    poke(17'h00200, 8'h78); poke(17'h00201, 8'h56);
    poke(17'h00202, 8'h34); poke(17'h00203, 8'h12);
    poke(17'h1FFFF, 8'hCD); poke(17'h00000, 8'hAB);
    poke(17'h00302, 8'h00); poke(17'h00303, 8'h00);
    rst = 1'b0;
    tick();

    $display("[TB] instruction fetch of 0x00010");
    bus.inst_req  = 1'b1;
    bus.inst_addr = 17'h00010;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_output("fetch_sig",  32'(bus.mem_vis_signal), 32'h1);
      check_output("fetch_addr", 32'(bus.mem_vis_addr), 32'h10 + 32'(c - 1));
      check_output("fetch_busy", 32'(bus.busy), 32'h1);
    end
    tick();
    check_output("fetch_drain_sig",  32'(bus.mem_vis_signal), 32'h0);
    check_output("fetch_drain_done", 32'(bus.inst_done), 32'h0);
    tick();
    check_output("fetch_done", 32'(bus.inst_done), 32'h1);
    check_output("fetch_data", bus.inst_data, 32'h00000513);
    check_output("fetch_done_sig", 32'(bus.mem_vis_signal), 32'h0);
    bus.inst_req = 1'b0;
    tick();
    check_output("fetch_pulse", 32'(bus.inst_done), 32'h0);
    check_output("fetch_idle",  32'(bus.busy), 32'h0);
    check_output("fetch_hold",  bus.inst_data, 32'h00000513);

    $display("[TB] byte store of 0xA5 to 0x00100");
    apply_stimulus(2'b10, 17'h00100, 2'b00, 32'h123456A5);
    tick();
    check_output("sb_sig",  32'(bus.mem_vis_signal), 32'h2);
    check_output("sb_addr", 32'(bus.mem_vis_addr), 32'h100);
    check_output("sb_wdat", 32'(bus.mem_writen_data), 32'hA5);
    tick();
    check_output("sb_done", 32'(bus.data_done), 32'h1);
    check_output("sb_done_sig", 32'(bus.mem_vis_signal), 32'h0);
    apply_stimulus(2'b00, 17'h0, 2'b00, 32'h0);
    tick();
    check_output("sb_pulse", 32'(bus.data_done), 32'h0);
    check_output("sb_mem0",  32'(mem[17'h00100]), 32'hA5);
    check_output("sb_mem1",  32'(mem[17'h00101]), 32'h77);

    $display("[TB] simultaneous fetch of 0x00020 and word load of 0x00200");
    bus.inst_req  = 1'b1;
    bus.inst_addr = 17'h00020;
    apply_stimulus(2'b01, 17'h00200, 2'b10, 32'h0);
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c <= 4) begin
        check_output("arb_dsig",  32'(bus.mem_vis_signal), 32'h1);
        check_output("arb_daddr", 32'(bus.mem_vis_addr), 32'h200 + 32'(c - 1));
      end
      if (c == 6) begin
        check_output("arb_ddone", 32'(bus.data_done), 32'h1);
        check_output("arb_rdata", bus.data_rdata, 32'h12345678);
        check_output("arb_idone_early", 32'(bus.inst_done), 32'h0);
        apply_stimulus(2'b00, 17'h0, 2'b00, 32'h0);
      end
      if (c == 7) check_output("arb_gap", 32'(bus.busy), 32'h0);
      if (c >= 8 && c <= 11) begin
        check_output("arb_isig",  32'(bus.mem_vis_signal), 32'h1);
        check_output("arb_iaddr", 32'(bus.mem_vis_addr), 32'h20 + 32'(c - 8));
      end
      if (c == 12) check_output("arb_idrain", 32'(bus.inst_done), 32'h0);
      if (c == 13) begin
        check_output("arb_idone", 32'(bus.inst_done), 32'h1);
        check_output("arb_idata", bus.inst_data, 32'h44332211);
        bus.inst_req = 1'b0;
      end
    end
    tick();

    $display("[TB] half load across the address wrap");
    apply_stimulus(2'b01, 17'h1FFFF, 2'b01, 32'h0);
    tick();
    check_output("wrap_addr0", 32'(bus.mem_vis_addr), 32'h1FFFF);
    tick();
    check_output("wrap_addr1", 32'(bus.mem_vis_addr), 32'h0);
    check_output("wrap_sig1",  32'(bus.mem_vis_signal), 32'h1);
    tick();
    check_output("wrap_drain", 32'(bus.data_done), 32'h0);
    tick();
    check_output("wrap_done",  32'(bus.data_done), 32'h1);
    check_output("wrap_rdata", bus.data_rdata, 32'h0000ABCD);
    apply_stimulus(2'b00, 17'h0, 2'b00, 32'h0);
    tick();

    $display("[TB] reset during a word store");
    apply_stimulus(2'b10, 17'h00300, 2'b10, 32'hCAFEF00D);
    tick();
    check_output("rw_wdat0", 32'(bus.mem_writen_data), 32'h0D);
    tick();
    check_output("rw_wdat1", 32'(bus.mem_writen_data), 32'hF0);
    check_output("rw_addr1", 32'(bus.mem_vis_addr), 32'h301);
    rst = 1'b1;
    tick();
    check_output("rw_sig",   32'(bus.mem_vis_signal), 32'h0);
    check_output("rw_busy",  32'(bus.busy), 32'h0);
    check_output("rw_done",  32'(bus.data_done), 32'h0);
    check_output("rw_rdata", bus.data_rdata, 32'h0);
    tick();
    check_output("rw_hold_busy", 32'(bus.busy), 32'h0);
    check_output("rw_hold_sig",  32'(bus.mem_vis_signal), 32'h0);
    rst = 1'b0;
    apply_stimulus(2'b00, 17'h0, 2'b00, 32'h0);
    tick();
    check_output("rw_mem0", 32'(mem[17'h00300]), 32'h0D);
    check_output("rw_mem1", 32'(mem[17'h00301]), 32'hF0);
    check_output("rw_mem2", 32'(mem[17'h00302]), 32'h00);
    apply_stimulus(2'b01, 17'h00301, 2'b00, 32'h0);
    tick();
    check_output("rw_new_sig",  32'(bus.mem_vis_signal), 32'h1);
    check_output("rw_new_addr", 32'(bus.mem_vis_addr), 32'h301);
    tick();
    tick();
    check_output("rw_new_done",  32'(bus.data_done), 32'h1);
    check_output("rw_new_rdata", bus.data_rdata, 32'h000000F0);
    apply_stimulus(2'b00, 17'h0, 2'b00, 32'h0);
    tick();

    $display("[TB] word store of 0xDEADBEEF to 0x00040 and read back");
    word = 32'hDEADBEEF;
    apply_stimulus(2'b10, 17'h00040, 2'b10, word);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_output("sw_wdat", 32'(bus.mem_writen_data), 32'(word[8*(c-1) +: 8]));
      check_output("sw_addr", 32'(bus.mem_vis_addr), 32'h40 + 32'(c - 1));
    end
    tick();
    check_output("sw_done", 32'(bus.data_done), 32'h1);
    apply_stimulus(2'b00, 17'h0, 2'b00, 32'h0);
    tick();
    for (int i = 0; i < 4; i++)
      check_output("sw_mem", 32'(mem[17'h00040 + 17'(i)]), 32'(word[8*i +: 8]));
    apply_stimulus(2'b01, 17'h00040, 2'b10, 32'h0);
    repeat (5) tick();
    check_output("lw_not_yet", 32'(bus.data_done), 32'h0);
    tick();
    check_output("lw_done",  32'(bus.data_done), 32'h1);
    check_output("lw_rdata", bus.data_rdata, 32'hDEADBEEF);
    apply_stimulus(2'b00, 17'h0, 2'b00, 32'h0);
    tick();
    check_output("lw_hold", bus.data_rdata, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
